// File: rtl/ipctrl.sv
// ipctrl -- input-port controller for a two-buffer, polarity-interleaved
// mesh router port.
//
// Two packet buffers (even/odd) alternate roles every cycle under the
// network-wide polarity signal: one buffer accepts a packet from upstream
// while the other presents its packet to the output controllers. On write,
// the XY route is computed and the matching hop count is decremented, so
// the presented packet is ready for the next hop.
//
// Ports:
//   clk       in   1   single clock, rising-edge state updates
//   reset     in   1   synchronous active-high reset
//   polarity  in   1   0 = even cycle (write odd, present even), 1 = odd cycle
//   send_in   in   1   upstream packet valid
//   data_in   in  64   upstream packet
//   ready_in  out  1   upstream may send next cycle (combinational)
//   data_out  out 64   presented packet (0 when presented buffer empty)
//   req       out  5   one-hot output request [0]=PE [1]=S [2]=N [3]=E [4]=W
//   clear     in   5   output-controller acceptance strobes, same order as req
//   drop_cnt  out  8   saturating dropped-packet count
//                      (only when IPCTRL_DROP_CNT_EN is defined)
//
// Configuration macro: IPCTRL_DROP_CNT_EN enables the drop counter and its port.

module ipctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        polarity,
  input  logic        send_in,
  input  logic [63:0] data_in,
  output logic        ready_in,
  output logic [63:0] data_out,
  output logic [4:0]  req,
  input  logic [4:0]  clear
`ifdef IPCTRL_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam logic [4:0] ROUTE_PE = 5'b00001;
  localparam logic [4:0] ROUTE_S  = 5'b00010;
  localparam logic [4:0] ROUTE_N  = 5'b00100;
  localparam logic [4:0] ROUTE_E  = 5'b01000;
  localparam logic [4:0] ROUTE_W  = 5'b10000;

  // XY routing: X hops are exhausted before any Y hop is taken.
  function automatic logic [4:0] xy_route(input logic [63:0] pkt);
    logic [4:0] r;
    if (pkt[55:52] != 4'd0) begin
      r = pkt[62] ? ROUTE_W : ROUTE_E;
    end else if (pkt[51:48] != 4'd0) begin
      r = pkt[61] ? ROUTE_S : ROUTE_N;
    end else begin
      r = ROUTE_PE;
    end
    return r;
  endfunction

  // Packet as it leaves this hop: the hop count of the chosen dimension is
  // decremented; a packet destined for the local PE passes unchanged.
  function automatic logic [63:0] hop_update(input logic [63:0] pkt);
    logic [63:0] p;
    p = pkt;
    if (pkt[55:52] != 4'd0) begin
      p[55:52] = pkt[55:52] - 4'd1;
    end else if (pkt[51:48] != 4'd0) begin
      p[51:48] = pkt[51:48] - 4'd1;
    end else begin
      p = pkt;
    end
    return p;
  endfunction

  logic [63:0] buf_even_data;
  logic [63:0] buf_odd_data;
  logic [4:0]  buf_even_route;
  logic [4:0]  buf_odd_route;
  logic        buf_even_full;
  logic        buf_odd_full;

  logic        pres_full;
  logic [4:0]  pres_route;
  logic [63:0] pres_data;
  logic        write_full;
  logic        accept;
  logic        do_write;
  logic [4:0]  new_route;
  logic [63:0] new_data;

  // Select presented/write buffer by polarity and derive handshake terms.
  always_comb begin
    pres_full  = 1'b0;
    pres_route = 5'd0;
    pres_data  = 64'd0;
    write_full = 1'b0;
    if (polarity) begin
      pres_full  = buf_odd_full;
      pres_route = buf_odd_route;
      pres_data  = buf_odd_data;
      write_full = buf_even_full;
    end else begin
      pres_full  = buf_even_full;
      pres_route = buf_even_route;
      pres_data  = buf_even_data;
      write_full = buf_odd_full;
    end
  end

  // Request and data are gated by the full flag so an empty buffer shows zero.
  always_comb begin
    req      = 5'd0;
    data_out = 64'd0;
    if (pres_full) begin
      req      = pres_route;
      data_out = pres_data;
    end else begin
      req      = 5'd0;
      data_out = 64'd0;
    end
  end

  // Only clear bits that match the active request count as an acceptance.
  assign accept    = (clear & req) != 5'd0;
  assign ready_in  = ~pres_full | accept;
  assign do_write  = send_in & ~write_full;
  assign new_route = xy_route(data_in);
  assign new_data  = hop_update(data_in);

  // Even buffer: written on odd cycles, accepted on even cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_even_full  <= 1'b0;
      buf_even_data  <= 64'd0;
      buf_even_route <= 5'd0;
    end else if (polarity && do_write) begin
      buf_even_full  <= 1'b1;
      buf_even_data  <= new_data;
      buf_even_route <= new_route;
    end else if (!polarity && accept) begin
      buf_even_full  <= 1'b0;
      buf_even_data  <= 64'd0;
      buf_even_route <= 5'd0;
    end else begin
      buf_even_full  <= buf_even_full;
      buf_even_data  <= buf_even_data;
      buf_even_route <= buf_even_route;
    end
  end

  // Odd buffer: written on even cycles, accepted on odd cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_odd_full  <= 1'b0;
      buf_odd_data  <= 64'd0;
      buf_odd_route <= 5'd0;
    end else if (!polarity && do_write) begin
      buf_odd_full  <= 1'b1;
      buf_odd_data  <= new_data;
      buf_odd_route <= new_route;
    end else if (polarity && accept) begin
      buf_odd_full  <= 1'b0;
      buf_odd_data  <= 64'd0;
      buf_odd_route <= 5'd0;
    end else begin
      buf_odd_full  <= buf_odd_full;
      buf_odd_data  <= buf_odd_data;
      buf_odd_route <= buf_odd_route;
    end
  end

`ifdef IPCTRL_DROP_CNT_EN
  logic drop;
  assign drop = send_in & write_full;

  // Saturating count of packets discarded because the write buffer was full.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'd255)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_ipctrl.sv
// tb_ipctrl -- self-checking bench for ipctrl: a hand-written vector table,
// directed multi-cycle sequences and a randomized run, all compared against
// an abstract two-slot buffer model kept in this file.
module tb_ipctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        polarity;
  logic        send_in;
  logic [63:0] data_in;
  logic        ready_in;
  logic [63:0] data_out;
  logic [4:0]  req;
  logic [4:0]  clear;
`ifdef IPCTRL_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  always #5 clk = ~clk;

  ipctrl dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (polarity),
    .send_in  (send_in),
    .data_in  (data_in),
    .ready_in (ready_in),
    .data_out (data_out),
    .req      (req),
    .clear    (clear)
`ifdef IPCTRL_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Model: slot 0 = even buffer, slot 1 = odd buffer.
  bit          m_full [2];
  logic [63:0] m_pkt  [2];
  logic [4:0]  m_route[2];
  int          m_drops;       // saturating, mirrors drop_cnt
  int          m_drop_events; // unsaturated
  int          m_out;
  bit          cur_pol;

  // Current-cycle stimulus and predictions.
  bit          c_rst;
  bit          c_snd;
  logic [63:0] c_d;
  logic [4:0]  c_clr;
  bit          c_acc;
  logic [4:0]  exp_req;
  logic [63:0] exp_data;
  bit          exp_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Routing rules straight from the header definition.
  function automatic void model_route(input logic [63:0] d, output logic [63:0] o,
                                      output logic [4:0] r);
    int hx;
    int hy;
    hx = int'(d[55:52]);
    hy = int'(d[51:48]);
    o  = d;
    if (hx > 0) begin
      r = d[62] ? 5'd16 : 5'd8;
      o[55:52] = 4'(hx - 1);
    end else if (hy > 0) begin
      r = d[61] ? 5'd2 : 5'd4;
      o[51:48] = 4'(hy - 1);
    end else begin
      r = 5'd1;
    end
  endfunction

  // Drive one cycle's inputs and compare outputs with the model before the edge.
  // match=1 makes clear equal to the expected request.
  task automatic apply(input bit rst, input bit snd, input logic [63:0] d,
                       input logic [4:0] clr, input bit match);
    int p;
    p = cur_pol ? 1 : 0;
    exp_req   = m_full[p] ? m_route[p] : 5'd0;
    exp_data  = m_full[p] ? m_pkt[p] : 64'd0;
    c_rst = rst; c_snd = snd; c_d = d;
    c_clr = match ? exp_req : clr;
    c_acc = (c_clr & exp_req) != 5'd0;
    exp_ready = !m_full[p] || c_acc;
    reset = rst; polarity = cur_pol; send_in = snd; data_in = d; clear = c_clr;
    #4;
    if (!rst) begin
      chk("model_req", {59'd0, req}, {59'd0, exp_req});
      chk("model_data", data_out, exp_data);
      chk("model_ready", {63'd0, ready_in}, {63'd0, exp_ready});
`ifdef IPCTRL_DROP_CNT_EN
      chk("model_drop_cnt", {56'd0, drop_cnt}, 64'(m_drops));
`endif
    end
  endtask

  // Clock edge: update the model with this cycle's effects.
  task automatic advance();
    int p;
    int w;
    logic [63:0] o;
    logic [4:0]  r;
    p = cur_pol ? 1 : 0;
    w = 1 - p;
    @(posedge clk);
    if (c_rst) begin
      for (int i = 0; i < 2; i++) begin
        m_full[i] = 1'b0; m_pkt[i] = 64'd0; m_route[i] = 5'd0;
      end
      m_drops = 0;
    end else begin
      if (c_snd) begin
        if (m_full[w]) begin
          m_drop_events++;
          if (m_drops < 255) m_drops++;
        end else begin
          model_route(c_d, o, r);
          m_pkt[w] = o; m_route[w] = r; m_full[w] = 1'b1;
        end
      end
      if (c_acc) begin
        m_full[p] = 1'b0;
        m_out++;
      end
    end
    cur_pol = !cur_pol;
    #1;
  endtask

  task automatic idle_to_pol(input bit want);
    if (cur_pol != want) begin
      apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
      advance();
    end
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 5'b11111, 1'b0);
    advance();
    apply(1'b1, 1'b0, 64'd0, 5'd0, 1'b0);
    advance();
  endtask

  typedef struct {
    bit          snd;
    logic [63:0] d;
    logic [4:0]  clr;
    logic [4:0]  e_req;
    bit          e_ready;
    logic [63:0] e_data;
  } vec_t;

  vec_t tbl[10];
  int   nreq;

  initial begin
    reset = 1'b1; polarity = 1'b0; send_in = 1'b0; data_in = 64'd0; clear = 5'd0;
    m_drops = 0; m_drop_events = 0; m_out = 0; cur_pol = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0; m_pkt[i] = 64'd0; m_route[i] = 5'd0;
    end

    // Hand-computed vectors, starting on an even cycle right after reset.
    tbl[0] = '{1'b1, 64'h0020_0000_0000_1234, 5'd0,     5'd0,     1'b1, 64'd0};
    tbl[1] = '{1'b0, 64'd0,                   5'd0,     5'b01000, 1'b0, 64'h0010_0000_0000_1234};
    tbl[2] = '{1'b0, 64'd0,                   5'd0,     5'd0,     1'b1, 64'd0};
    tbl[3] = '{1'b0, 64'd0,                   5'b01000, 5'b01000, 1'b1, 64'h0010_0000_0000_1234};
    tbl[4] = '{1'b1, 64'h8900_1111_2222_3333, 5'd0,     5'd0,     1'b1, 64'd0};
    tbl[5] = '{1'b0, 64'd0,                   5'd0,     5'b00001, 1'b0, 64'h8900_1111_2222_3333};
    tbl[6] = '{1'b0, 64'd0,                   5'd0,     5'd0,     1'b1, 64'd0};
    tbl[7] = '{1'b0, 64'd0,                   5'b00001, 5'b00001, 1'b1, 64'h8900_1111_2222_3333};
    tbl[8] = '{1'b0, 64'd0,                   5'd0,     5'd0,     1'b1, 64'd0};
    tbl[9] = '{1'b0, 64'd0,                   5'd0,     5'd0,     1'b1, 64'd0};

    @(posedge clk);
    #1;
    do_reset();
    cur_pol = 1'b0;

    // Reset state.
    apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    chk("reset_req", {59'd0, req}, 64'd0);
    chk("reset_data", data_out, 64'd0);
    chk("reset_ready", {63'd0, ready_in}, 64'd1);
    advance();
    idle_to_pol(1'b0);

    // Table: E route with hop decrement, PE route, accept and empty.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, tbl[i].snd, tbl[i].d, tbl[i].clr, 1'b0);
      chk($sformatf("tbl%0d_req", i), {59'd0, req}, {59'd0, tbl[i].e_req});
      chk($sformatf("tbl%0d_ready", i), {63'd0, ready_in}, {63'd0, tbl[i].e_ready});
      chk($sformatf("tbl%0d_data", i), data_out, tbl[i].e_data);
      advance();
    end

    // Mismatched clear never drops a held packet.
    idle_to_pol(1'b0);
    apply(1'b0, 1'b1, 64'h2003_0000_0000_0042, 5'd0, 1'b0);
    advance();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 64'd0, 5'b00100, 1'b0);
      chk("hold_req", {59'd0, req}, 64'h2);
      chk("hold_data", data_out, 64'h2002_0000_0000_0042);
      advance();
      apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
      advance();
    end
    apply(1'b0, 1'b0, 64'd0, 5'b00010, 1'b0);
    chk("hold_clear_ready", {63'd0, ready_in}, 64'd1);
    advance();
    apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    advance();
    apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    chk("hold_emptied_req", {59'd0, req}, 64'd0);
    advance();

    // Both buffers full, then drops.
    idle_to_pol(1'b0);
    apply(1'b0, 1'b1, 64'h0030_0000_0000_00AA, 5'd0, 1'b0);
    advance();
    apply(1'b0, 1'b1, 64'h4050_0000_0000_00BB, 5'd0, 1'b0);
    advance();
    apply(1'b0, 1'b1, 64'h0000_0000_0000_0CCC, 5'd0, 1'b0);
    chk("full_even_req", {59'd0, req}, 64'h10);
    chk("full_even_data", data_out, 64'h4040_0000_0000_00BB);
    advance();
    apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    chk("drop_odd_data", data_out, 64'h0020_0000_0000_00AA);
    chk("drop_odd_req", {59'd0, req}, 64'h8);
`ifdef IPCTRL_DROP_CNT_EN
    chk("drop_cnt_one", {56'd0, drop_cnt}, 64'd1);
`endif
    advance();
    for (int k = 0; k < 300; k++) begin
      apply(1'b0, 1'b1, {$urandom, $urandom}, 5'd0, 1'b0);
      advance();
    end
    apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    chk("drop_ready_full", {63'd0, ready_in}, 64'd0);
`ifdef IPCTRL_DROP_CNT_EN
    chk("drop_cnt_sat", {56'd0, drop_cnt}, 64'd255);
`endif
    advance();

    // Reset while both buffers are full.
    apply(1'b1, 1'b1, 64'h0011_0000_0000_0001, 5'b11111, 1'b0);
    advance();
    apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    chk("rst_full_req", {59'd0, req}, 64'd0);
    chk("rst_full_data", data_out, 64'd0);
    chk("rst_full_ready", {63'd0, ready_in}, 64'd1);
`ifdef IPCTRL_DROP_CNT_EN
    chk("rst_full_drop_cnt", {56'd0, drop_cnt}, 64'd0);
`endif
    advance();
    apply(1'b0, 1'b0, 64'd0, 5'd0, 1'b0);
    chk("rst_full_req2", {59'd0, req}, 64'd0);
    advance();

    // Back-to-back streaming with matching clears.
    idle_to_pol(1'b0);
    nreq = 0;
    begin
      int drops0;
      drops0 = m_drop_events;
      for (int k = 0; k < 40; k++) begin
        apply(1'b0, 1'b1, {$urandom, $urandom}, 5'd0, 1'b1);
        chk("b2b_ready", {63'd0, ready_in}, 64'd1);
        if (req != 5'd0) nreq++;
        advance();
      end
      chk("b2b_out_count", 64'(nreq), 64'd39);
      chk("b2b_no_drops", 64'(m_drop_events - drops0), 64'd0);
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      apply(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom},
            5'($urandom), mode == 0);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ipctrl.md
IPCTRL -- requirements
Module: ipctrl

Interface
REQ-001 Parameters: none; data width fixed at 64.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 polarity  input  1  0 = even cycle, 1 = odd cycle; toggles every cycle, network-wide.
REQ-005 send_in  input  1  upstream data valid this cycle.
REQ-006 data_in  input  64  upstream packet.
REQ-007 ready_in  output  1  combinational; upstream may send next cycle.
REQ-008 data_out  output  64  presented packet, hop count already updated.
REQ-009 req  output  5  one-hot output request, bit order [0]=PE [1]=S [2]=N [3]=E [4]=W.
REQ-010 clear  input  5  per-output-controller acceptance strobe, same bit order as req.
REQ-011 drop_cnt  output  8  dropped-packet count; present only under IPCTRL_DROP_CNT_EN.

Function
REQ-012 Two buffers, buf_even and buf_odd, each with full flag and stored 5-bit route.
REQ-013 polarity=0: upstream writes buf_odd, buf_even is presented; polarity=1: upstream writes buf_even, buf_odd is presented.
REQ-014 Header fields: [62] x_dir (0=E,1=W), [61] y_dir (0=N,1=S), [55:52] hx unsigned, [51:48] hy unsigned; all other bits pass unchanged.
REQ-015 Write: send_in=1 and write buffer empty -> at edge store packet, set full, compute route (XY order):
  - hx!=0 -> E or W per x_dir; store hx-1.
  - hx=0, hy!=0 -> N or S per y_dir; store hy-1.
  - hx=0, hy=0 -> PE; fields unchanged.
REQ-016 Presentation: req = stored route when presented buffer full, else 5'b0; data_out = presented buffer contents, 0 when empty.
REQ-017 Accept: (clear & req)!=0 -> presented buffer empties at edge; clear bits not matching req are ignored.
REQ-018 ready_in = presented buffer empty OR (clear & req)!=0 this cycle.
REQ-019 Latency: packet written at edge closing cycle t is requested in cycle t+1; no request without grant-clear ever drops a held packet.
REQ-020 send_in=1 while write buffer full -> packet discarded, buffer unchanged (drop event).
REQ-021 Write and clear on different buffers in the same cycle both take effect.
REQ-022 send_in=0 -> write buffer unchanged.

Reset
REQ-023 reset=1 at edge: both buffers empty, contents and routes 0, drop_cnt 0; so req=0, data_out=0, ready_in=1.
REQ-024 Reset mid-operation discards held packets; send_in/clear in the reset cycle are ignored.

Configuration
REQ-025 Macro IPCTRL_DROP_CNT_EN defined: drop_cnt port exists, increments by 1 per drop event, saturates at 255.
REQ-026 Macro undefined: no drop_cnt port, no counter logic; drops still silent per REQ-020.

Verification
REQ-027 Reset, then polarity=0, send_in=1, data_in hx=2 x_dir=0 -> cycle t+1 (pol=1): req=5'b01000, data_out[55:52]=1.
REQ-028 Packet hx=0 hy=0 -> req=5'b00001, data_out equals data_in; clear=5'b00001 -> next cycle req=0, ready_in=1 during clear cycle.
REQ-029 Packet hx=0 hy=3 y_dir=1 held, clear=5'b00100 (mismatch) for 4 cycles -> req stays 5'b00010, packet retained; clear=5'b00010 -> empties.
REQ-030 Both buffers full, send_in=1 -> packet dropped, held data unchanged, drop_cnt 0->1 (macro on); 300 drops -> drop_cnt=255.
REQ-031 Back-to-back: send_in=1 every cycle with clear matching req every cycle -> one packet out per cycle, ready_in constantly 1, no drops.
REQ-032 Reset asserted while both buffers full -> next cycle req=0, data_out=0, drop_cnt=0.
